// File: rtl/cp0.sv
// +---------------------------------------------------------------------------+
// | cp0 : MIPS coprocessor 0 (SR, CAUSE, EPC, PRID) with gated interrupt req.  |
// | Optional macro CP0_IP_STICKY_EN makes CAUSE.ip sticky, write-1-to-clear.   |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
`default_nettype none

module cp0 #(
   parameter logic [31:0] PRID_VAL = 32'h0000_C5C5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  sel,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   input  logic [29:0] pc,
   input  logic        exl_set,
   input  logic        exl_clr,
   input  logic [5:0]  hwint,
   output logic        irq,
   output logic [29:0] epc
);

   localparam logic [4:0] C_SEL_SR    = 5'd12;
   localparam logic [4:0] C_SEL_CAUSE = 5'd13;
   localparam logic [4:0] C_SEL_EPC   = 5'd14;
   localparam logic [4:0] C_SEL_PRID  = 5'd15;

   logic [5:0]  im_q,  im_d;
   logic [5:0]  ip_q,  ip_d;
   logic        exl_q, exl_d;
   logic        ie_q,  ie_d;
   logic [29:0] epc_q, epc_d;

   logic w_wr_sr;
   logic w_wr_cause;
   logic w_wr_epc;
   logic w_exl_accept;

   assign w_wr_sr      = we && (sel == C_SEL_SR);
   assign w_wr_cause   = we && (sel == C_SEL_CAUSE);
   assign w_wr_epc     = we && (sel == C_SEL_EPC);
   // A nested entry must not clobber the EPC of the handler already running.
   assign w_exl_accept = exl_set && !exl_q;

   always_comb begin
      im_d  = im_q;
      ie_d  = ie_q;
      exl_d = exl_q;
      epc_d = epc_q;
      ip_d  = ip_q;

      if (w_wr_sr) begin
         im_d = din[15:10];
         ie_d = din[0];
      end

      if (w_exl_accept) begin
         exl_d = 1'b1;
      end else if (exl_clr) begin
         exl_d = 1'b0;
      end else if (w_wr_sr) begin
         exl_d = din[1];
      end

      if (w_exl_accept) begin
         epc_d = pc;
      end else if (w_wr_epc) begin
         epc_d = din[31:2];
      end

`ifdef CP0_IP_STICKY_EN
      // Set after clear so a line asserted in the clearing cycle is kept.
      ip_d = (ip_q & ~(w_wr_cause ? din[15:10] : 6'b0)) | hwint;
`else
      ip_d = hwint;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         im_q  <= 6'b0;
         ip_q  <= 6'b0;
         exl_q <= 1'b0;
         ie_q  <= 1'b0;
         epc_q <= 30'b0;
      end else begin
         im_q  <= im_d;
         ip_q  <= ip_d;
         exl_q <= exl_d;
         ie_q  <= ie_d;
         epc_q <= epc_d;
      end
   end

   always_comb begin
      case (sel)
         C_SEL_SR:    dout = {16'b0, im_q, 8'b0, exl_q, ie_q};
         C_SEL_CAUSE: dout = {16'b0, ip_q, 10'b0};
         C_SEL_EPC:   dout = {epc_q, 2'b00};
         C_SEL_PRID:  dout = PRID_VAL;
         default:     dout = 32'b0;
      endcase
   end

   assign irq = (|(ip_q & im_q)) && ie_q && !exl_q;
   assign epc = epc_q;

endmodule

`default_nettype wire

// File: tb/tb_cp0.sv
// +---------------------------------------------------------------------------+
// | tb_cp0 : scoreboard bench for cp0, directed scenarios plus random traffic. |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_cp0;

   logic        clk;
   logic        rst;
   logic [4:0]  sel;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;
   logic [29:0] pc;
   logic        exl_set;
   logic        exl_clr;
   logic [5:0]  hwint;
   logic        irq;
   logic [29:0] epc;

   cp0 dut (
      .clk     (clk),
      .rst     (rst),
      .sel     (sel),
      .we      (we),
      .din     (din),
      .dout    (dout),
      .pc      (pc),
      .exl_set (exl_set),
      .exl_clr (exl_clr),
      .hwint   (hwint),
      .irq     (irq),
      .epc     (epc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        chk;
      logic [31:0] dout;
      logic        irq;
      logic [29:0] epc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   stim_done = 1'b0;

   localparam logic [32:0] NO = 33'h0;

   // Reference state kept as architectural register words.
   logic [31:0] m_sr, m_cause, m_epc;
   bit          m_valid = 1'b0;

   function automatic logic [31:0] m_read(input logic [4:0] s);
      case (s)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return 32'h0000_C5C5;
         default: return 32'h0;
      endcase
   endfunction

   task automatic step(input logic r, input logic w, input logic [4:0] s,
                       input logic [31:0] d, input logic [29:0] p,
                       input logic es, input logic ec, input logic [5:0] hw,
                       input logic [32:0] ov_dout, input int ov_irq);
      exp_t        e;
      logic [31:0] sr_n, cause_n, epc_n, clr;
      bit          accept;
      @(negedge clk);
      rst = r; we = w; sel = s; din = d; pc = p;
      exl_set = es; exl_clr = ec; hwint = hw;
      #1;
      e.chk  = m_valid;
      e.dout = ov_dout[32] ? ov_dout[31:0] : m_read(s);
      e.irq  = (ov_irq >= 0) ? ov_irq[0]
             : (((m_cause & m_sr & 32'h0000_FC00) != 0) && m_sr[0] && !m_sr[1]);
      e.epc  = m_epc[31:2];
      sb.push_back(e);

      if (r) begin
         m_sr = 0; m_cause = 0; m_epc = 0; m_valid = 1'b1;
      end else begin
         accept = es && !m_sr[1];
         sr_n = (w && s == 5'd12) ? (d & 32'h0000_FC03) : m_sr;
         if (accept) sr_n[1] = 1'b1;
         else if (ec) sr_n[1] = 1'b0;
         epc_n = m_epc;
         if (accept) epc_n = {p, 2'b00};
         else if (w && s == 5'd14) epc_n = d & 32'hFFFF_FFFC;
`ifdef CP0_IP_STICKY_EN
         clr = (w && s == 5'd13) ? (d & 32'h0000_FC00) : 32'h0;
         cause_n = (m_cause & ~clr) | ({26'b0, hw} << 10);
`else
         clr = 32'h0;
         cause_n = {26'b0, hw} << 10;
`endif
         m_sr = sr_n; m_cause = cause_n | clr & 32'h0 ; m_epc = epc_n;
      end
   endtask

   // Monitor: the DUT presents a result every cycle; compare mid low phase.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
               n_cmp++;
               if (dout !== e.dout) begin
                  n_bad++;
                  $display("FAIL dout sel=%0d actual=%h required=%h t=%0t", sel, dout, e.dout, $time);
               end
               n_cmp++;
               if (irq !== e.irq) begin
                  n_bad++;
                  $display("FAIL irq actual=%b required=%b t=%0t", irq, e.irq, $time);
               end
               n_cmp++;
               if (epc !== e.epc) begin
                  n_bad++;
                  $display("FAIL epc actual=%h required=%h t=%0t", epc, e.epc, $time);
               end
            end
         end
      end
   end

   initial begin
      logic       r, w, es, ec;
      logic [4:0] s;
      logic [5:0] hw;
      rst = 1'b1; we = 1'b0; sel = 5'd0; din = 32'h0; pc = 30'h0;
      exl_set = 1'b0; exl_clr = 1'b0; hwint = 6'h0;

      // Reset and read-back of reset values
      step(1, 0, 12, 0, 0, 0, 0, 0, NO, -1);
      step(1, 0, 12, 0, 0, 0, 0, 0, NO, -1);
      step(0, 0, 12, 0, 0, 0, 0, 0, {1'b1, 32'h0}, 0);
      step(0, 0, 13, 0, 0, 0, 0, 0, {1'b1, 32'h0}, 0);
      step(0, 0, 14, 0, 0, 0, 0, 0, {1'b1, 32'h0}, 0);
      step(0, 0, 15, 0, 0, 0, 0, 0, {1'b1, 32'h0000_C5C5}, 0);

      // Timer line on hwint[2]
      step(0, 1, 12, 32'h0000_0401, 0, 0, 0, 6'h00, NO, -1);
      step(0, 0, 12, 0, 0, 0, 0, 6'h01, {1'b1, 32'h0000_0401}, 0);
      step(0, 0, 13, 0, 0, 0, 0, 6'h01, {1'b1, 32'h0000_0400}, 1);

      // Entry, nested entry, return
      step(0, 0, 12, 0, 30'h0000_0C10, 1, 0, 6'h01, {1'b1, 32'h0000_0401}, 1);
      step(0, 0, 14, 0, 0, 0, 0, 6'h01, {1'b1, 32'h0000_3040}, 0);
      step(0, 0, 12, 0, 0, 0, 0, 6'h01, {1'b1, 32'h0000_0403}, 0);
      step(0, 0, 14, 0, 30'h123, 1, 0, 6'h01, {1'b1, 32'h0000_3040}, 0);
      step(0, 0, 14, 0, 0, 0, 0, 6'h01, {1'b1, 32'h0000_3040}, 0);
      step(0, 0, 12, 0, 0, 0, 1, 6'h01, {1'b1, 32'h0000_0403}, 0);
      step(0, 0, 12, 0, 0, 0, 0, 6'h01, {1'b1, 32'h0000_0401}, 1);

      // Masking
      step(0, 1, 12, 32'h0000_0001, 0, 0, 0, 6'h3F, NO, -1);
      step(0, 1, 12, 32'h0000_8000, 0, 0, 0, 6'h3F, {1'b1, 32'h0000_0001}, 0);
      step(0, 1, 12, 32'h0000_8001, 0, 0, 0, 6'h3F, {1'b1, 32'h0000_8000}, 0);
      step(0, 0, 12, 0, 0, 0, 0, 6'h3F, {1'b1, 32'h0000_8001}, 1);

      // Simultaneous SR write with exl_set and exl_clr; EPC write
      step(0, 1, 12, 32'h0000_0401, 30'h5, 1, 1, 6'h00, {1'b1, 32'h0000_8001}, 1);
      step(0, 0, 12, 0, 0, 0, 0, 6'h00, {1'b1, 32'h0000_0403}, 0);
      step(0, 1, 14, 32'h0000_0ABC, 0, 0, 0, 6'h00, NO, 0);
      step(0, 0, 14, 0, 0, 0, 0, 6'h00, {1'b1, 32'h0000_0ABC}, 0);

      // One-cycle pulse on hwint[3]
      step(0, 1, 13, 32'h0000_FC00, 0, 0, 1, 6'h00, NO, -1);
      step(0, 0, 13, 0, 0, 0, 0, 6'h02, {1'b1, 32'h0}, -1);
      step(0, 0, 13, 0, 0, 0, 0, 6'h00, {1'b1, 32'h0000_0800}, -1);
`ifdef CP0_IP_STICKY_EN
      step(0, 0, 13, 0, 0, 0, 0, 6'h00, {1'b1, 32'h0000_0800}, -1);
      step(0, 1, 13, 32'h0000_0800, 0, 0, 0, 6'h00, {1'b1, 32'h0000_0800}, -1);
      step(0, 0, 13, 0, 0, 0, 0, 6'h00, {1'b1, 32'h0}, -1);
`else
      step(0, 0, 13, 0, 0, 0, 0, 6'h00, {1'b1, 32'h0}, -1);
`endif

      // Randomized traffic
      hw = 6'h0;
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom % 97) == 0;
         w  = ($urandom % 4) == 0;
         s  = 5'(10 + $urandom % 7);
         es = ($urandom % 8) == 0;
         ec = ($urandom % 8) == 0;
         if (es && ec && m_sr[1]) ec = 1'b0;
         if (($urandom % 4) == 0) hw = 6'($urandom);
         step(r, w, s, $urandom, 30'($urandom), es, ec, hw, NO, -1);
      end

      stim_done = 1'b1;
      @(negedge clk);
      #5;
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain actual=%0d pending required=0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
